// File: rtl/fetch_decode_queue.sv
// fetch_decode_queue: circular instruction buffer between fetch and decode.
// Holds {instr, pc} pairs in FIFO order, valid/ready on both sides, with a
// flush that drops every buffered entry on a pipeline redirect.
module fetch_decode_queue #(
    parameter type T     = logic [31:0],
    parameter int  DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_flush,
    input  logic [31:0]              i_instr,
    input  logic [31:0]              i_pc,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [31:0]              o_instr,
    output logic [31:0]              o_pc,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    T              instr_mem_q [DEPTH];
    T              instr_mem_d [DEPTH];
    T              pc_mem_q    [DEPTH];
    T              pc_mem_d    [DEPTH];

    logic enq, deq;

    // Handshake outputs come only from registered state (plus reset), so
    // there is no combinational path from the fetch inputs to the head.
    always_comb begin
        o_ready = (count_q != CW'(DEPTH)) & ~reset;
        o_valid = (count_q != '0) & ~reset;
        o_instr = o_valid ? 32'(instr_mem_q[rd_ptr_q]) : 32'h0;
        o_pc    = o_valid ? 32'(pc_mem_q[rd_ptr_q]) : 32'h0;
        o_count = count_q;
        enq     = i_valid & o_ready;
        deq     = o_valid & i_ready;
    end

    // Next-state: flush discards the cycle's enq/deq and empties the queue
    // by snapping the read pointer onto the write pointer.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        instr_mem_d = instr_mem_q;
        pc_mem_d    = pc_mem_q;
        if (i_flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (enq) begin
                instr_mem_d[wr_ptr_q] = T'(i_instr);
                pc_mem_d[wr_ptr_q]    = T'(i_pc);
                wr_ptr_d              = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer/count registers with synchronous reset; reset beats flush.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset: the head is masked to zero when empty.
    always_ff @(posedge clk) begin
        instr_mem_q <= instr_mem_d;
        pc_mem_q    <= pc_mem_d;
    end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Bench for fetch_decode_queue: directed scenarios followed by random
// traffic, every cycle compared against a queue-based reference model.
module tb_fetch_decode_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_flush = 1'b0;
    logic [31:0] i_instr = '0;
    logic [31:0] i_pc = '0;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_ready, o_valid;
    logic [31:0] o_instr, o_pc;
    logic [2:0]  o_count;

    fetch_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .i_flush(i_flush),
        .i_instr(i_instr), .i_pc(i_pc), .i_valid(i_valid), .o_ready(o_ready),
        .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid), .i_ready(i_ready),
        .o_count(o_count)
    );

    always #5 clk = ~clk;

    logic [63:0] mq[$];   // {instr, pc}, head at index 0
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    // One clock cycle: apply inputs, compare outputs against the model at the
    // falling edge, then advance the model at the rising edge.
    task automatic step(input bit rst, input bit fl, input bit v,
                        input logic [31:0] ins, input logic [31:0] pc, input bit rd);
        bit e_rdy, e_vld, enq, deq;
        logic [31:0] e_ins, e_pc;
        logic [63:0] junk;
        reset = rst; i_flush = fl; i_valid = v; i_instr = ins; i_pc = pc; i_ready = rd;
        @(negedge clk);
        e_rdy = !rst && (mq.size() < DEPTH);
        e_vld = !rst && (mq.size() > 0);
        e_ins = e_vld ? mq[0][63:32] : 32'h0;
        e_pc  = e_vld ? mq[0][31:0]  : 32'h0;
        chk("o_ready", {31'b0, o_ready}, {31'b0, e_rdy});
        chk("o_valid", {31'b0, o_valid}, {31'b0, e_vld});
        chk("o_instr", o_instr, e_ins);
        chk("o_pc",    o_pc,    e_pc);
        chk("o_count", {29'b0, o_count}, 32'(mq.size()));
        enq = v && e_rdy;
        deq = e_vld && rd;
        @(posedge clk);
        if (rst || fl) mq.delete();
        else begin
            if (deq) junk = mq.pop_front();
            if (enq) mq.push_back({ins, pc});
        end
        #1;
    endtask

    initial begin
        logic [31:0] pcn;
        // Establish a known state before any comparison.
        @(posedge clk); #1;
        step(1, 0, 0, 0, 0, 0);          // reset held: ready/valid forced low
        step(0, 0, 0, 0, 0, 0);          // post-reset: empty, ready=1, zeros

        // Single push, held while decoder stalls.
        step(0, 0, 1, 32'h13, 32'h0, 0);
        chk("t1_instr", o_instr, 32'h13);
        chk("t1_count", {29'b0, o_count}, 32'd1);
        repeat (3) step(0, 0, 0, 32'hdead, 32'hbeef, 0);
        step(0, 0, 0, 0, 0, 1);          // consume it
        step(0, 0, 0, 0, 0, 0);

        // Fill to full, then simultaneous valid/ready while full.
        pcn = 0;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, 32'h100 + pcn, pcn, 0);
            pcn += 4;
        end
        chk("full_count", {29'b0, o_count}, 32'd4);
        chk("full_ready", {31'b0, o_ready}, 32'd0);
        step(0, 0, 1, 32'h999, 32'h999, 1);   // deq happens, enq refused
        chk("full_deq_count", {29'b0, o_count}, 32'd3);
        chk("full_deq_head", o_pc, 32'h4);
        repeat (4) step(0, 0, 0, 0, 0, 1);    // drain 0x4,0x8,0xC

        // Steady stream: count stays 1, pointers wrap.
        pcn = 32'h40;
        step(0, 0, 1, 32'h200, pcn, 1); pcn += 4;
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1, 32'h200 + pcn, pcn, 1);
            pcn += 4;
        end
        chk("stream_count", {29'b0, o_count}, 32'd1);
        step(0, 0, 0, 0, 0, 1);

        // Three queued, then flush with a concurrent push.
        for (int k = 0; k < 3; k++) step(0, 0, 1, 32'h300 + k, 32'h80 + 4 * k, 0);
        step(0, 1, 1, 32'h777, 32'h777, 1);
        chk("flush_valid", {31'b0, o_valid}, 32'd0);
        chk("flush_count", {29'b0, o_count}, 32'd0);
        step(0, 0, 0, 0, 0, 0);

        // Reset with two queued, then a push after release.
        for (int k = 0; k < 2; k++) step(0, 0, 1, 32'h400 + k, 32'hc0 + 4 * k, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_count", {29'b0, o_count}, 32'd0);
        step(0, 0, 1, 32'h55, 32'h1000, 0);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0);

        // Random traffic.
        for (int k = 0; k < 400; k++) begin
            step($urandom_range(0, 99) == 0, $urandom_range(0, 19) == 0,
                 $urandom_range(0, 9) < 7, $urandom, $urandom,
                 $urandom_range(0, 9) < 6);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
